// File: rtl/ef_wb_cmd_master.sv
// Wishbone classic single-cycle bus master driven by a one-deep command port.
// Executes single writes, single reads, and reads repeated until masked bits are set.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// BUS   | cyc_o/stb_o high, waiting for ack_i or the ack timeout
// CHECK | one cycle to test poll data against the mask
// WAIT  | idle gap (cyc_o low) before the next poll read
// RESP  | rsp_valid high, response held until rsp_ready
module ef_wb_cmd_master #(
  parameter int POLL_MAX = 1024,
  parameter int ACK_TO   = 64,
  parameter int GAP      = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_poll,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_err,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i
);

  localparam int AW = $clog2(ACK_TO + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ACK  = 2'b01;
  localparam logic [1:0] ERR_POLL = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_BUS, S_CHECK, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [31:0]    adr_q, adr_d;
  logic [31:0]    dat_q, dat_d;
  logic [31:0]    mask_q, mask_d;
  logic           we_q, we_d;
  logic           poll_q, poll_d;
  logic [31:0]    rsp_dat_q, rsp_dat_d;
  logic [1:0]     rsp_err_q, rsp_err_d;
  logic [AW-1:0]  ack_cnt_q, ack_cnt_d;
  logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;

  // State and datapath registers; reset discards any command in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      poll_q     <= 1'b0;
      rsp_dat_q  <= '0;
      rsp_err_q  <= ERR_OK;
      ack_cnt_q  <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      mask_q     <= mask_d;
      we_q       <= we_d;
      poll_q     <= poll_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_err_q  <= rsp_err_d;
      ack_cnt_q  <= ack_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Next-state and datapath updates for the command sequence.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    mask_d     = mask_q;
    we_d       = we_q;
    poll_d     = poll_q;
    rsp_dat_d  = rsp_dat_q;
    rsp_err_d  = rsp_err_q;
    ack_cnt_d  = ack_cnt_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          adr_d      = cmd_adr;
          dat_d      = cmd_dat;
          mask_d     = cmd_mask;
          we_d       = cmd_we;
          poll_d     = cmd_poll & ~cmd_we;
          ack_cnt_d  = '0;
          poll_cnt_d = '0;
          state_d    = S_BUS;
        end
      end
      S_BUS: begin
        // An ack in the timeout cycle still completes the transfer normally.
        if (ack_i) begin
          rsp_dat_d = we_q ? dat_q : dat_i;
          if (poll_q) begin
            state_d = S_CHECK;
          end else begin
            rsp_err_d = ERR_OK;
            state_d   = S_RESP;
          end
        end else if (ack_cnt_q == AW'(ACK_TO - 1)) begin
          ack_cnt_d = AW'(ACK_TO);
          rsp_dat_d = '0;
          rsp_err_d = ERR_ACK;
          state_d   = S_RESP;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if ((rsp_dat_q & mask_q) != '0) begin
          rsp_err_d = ERR_OK;
          state_d   = S_RESP;
        end else if (poll_cnt_q == PW'(POLL_MAX - 1)) begin
          rsp_err_d = ERR_POLL;
          state_d   = S_RESP;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          ack_cnt_d  = '0;
          gap_cnt_d  = GW'(GAP - 1);
          state_d    = (GAP == 0) ? S_BUS : S_WAIT;
        end
      end
      S_WAIT: begin
        // Down-counter loaded with GAP-1 in CHECK; terminal count re-enters BUS.
        if (gap_cnt_q == '0) begin
          ack_cnt_d = '0;
          state_d   = S_BUS;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign cyc_o     = (state_q == S_BUS);
  assign stb_o     = (state_q == S_BUS);
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign we_o      = we_q;
  assign sel_o     = 4'hF;

endmodule
